// File: rtl/register_file_mc_pkg.sv
// Shared types and sizing for the renamed architectural register file.
// A register holds either a committed value or the tag of its pending producer.
package register_file_mc_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_REGS   = 32;
  localparam int NUM_READ   = 2;
  localparam int NUM_BCAST  = 2;
  localparam bit ZERO_REG   = 1'b1;
  localparam int RIDX_W     = $clog2(NUM_REGS);
  localparam int PCNT_W     = $clog2(NUM_REGS + 1);

  typedef enum logic [2:0] {
    FU_NONE = 3'd0,
    FU_ALU0 = 3'd1,
    FU_ALU1 = 3'd2,
    FU_MUL  = 3'd3,
    FU_LSU  = 3'd4,
    FU_BR   = 3'd5
  } e_functional_unit;

  // While virtual, value keeps the last committed data so a flush can fall back to it.
  typedef struct packed {
    logic                  is_virtual;
    e_functional_unit      rs_id;
    logic [DATA_WIDTH-1:0] value;
  } register_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] value;
    e_functional_unit      rs;
  } bcast_t;

  function automatic logic is_zero_reg(logic [RIDX_W-1:0] idx);
    return ZERO_REG && (idx == '0);
  endfunction

endpackage

// File: rtl/register_file_mc_tag_match.sv
// Matches one register entry against every result bus; the lowest channel wins
// when several carry the same tag.
module register_file_mc_tag_match
  import register_file_mc_pkg::*;
(
  input  register_t                       entry_i,
  input  bcast_t    [NUM_BCAST-1:0]        bcast_i,
  output logic                            hit_o,
  output logic      [DATA_WIDTH-1:0]       value_o
);

  // Walking from the top down lets the lowest matching channel overwrite the rest.
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    for (int i = NUM_BCAST - 1; i >= 0; i--) begin
      if (entry_i.is_virtual && bcast_i[i].valid && (bcast_i[i].rs == entry_i.rs_id)) begin
        hit_o   = 1'b1;
        value_o = bcast_i[i].value;
      end
    end
  end

endmodule

// File: rtl/register_file_mc.sv
// Architectural register file with rename tags, multi-channel result broadcast,
// same-cycle broadcast bypass on reads, flush of pending tags and a pending counter.
module register_file_mc
  import register_file_mc_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   issue_wr_en_i,
  input  logic             [RIDX_W-1:0]          issue_dst_i,
  input  e_functional_unit                       issue_rs_i,
  input  logic             [NUM_BCAST-1:0]       bcast_valid_i,
  input  logic             [NUM_BCAST-1:0][DATA_WIDTH-1:0] bcast_value_i,
  input  e_functional_unit [NUM_BCAST-1:0]       bcast_rs_i,
  input  logic                                   flush_i,
  input  logic             [NUM_READ-1:0][RIDX_W-1:0] read_reg_i,
  output register_t        [NUM_READ-1:0]        read_value_o,
  output logic             [PCNT_W-1:0]          pending_cnt_o
);

  register_t                  regs_q [NUM_REGS];
  register_t                  regs_d [NUM_REGS];
  logic      [PCNT_W-1:0]     cnt_q, cnt_d;
  logic      [PCNT_W-1:0]     n_cleared;
  logic      [PCNT_W-1:0]     virt_pop;
  logic      [NUM_REGS-1:0]   hit;
  logic      [DATA_WIDTH-1:0] hit_value [NUM_REGS];
  bcast_t    [NUM_BCAST-1:0]  cdb;
  logic                       issue_eff;
  logic                       issue_new;

  always_comb begin
    for (int c = 0; c < NUM_BCAST; c++) begin
      cdb[c].valid = bcast_valid_i[c];
      cdb[c].value = bcast_value_i[c];
      cdb[c].rs    = bcast_rs_i[c];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_match
    register_file_mc_tag_match u_match (
      .entry_i (regs_q[g]),
      .bcast_i (cdb),
      .hit_o   (hit[g]),
      .value_o (hit_value[g])
    );
  end

  assign issue_eff = issue_wr_en_i && !flush_i && !is_zero_reg(issue_dst_i);
  assign issue_new = issue_eff && !regs_q[issue_dst_i].is_virtual;

  // A newer issue replaces a resolving broadcast on the same register and keeps the old commit.
  always_comb begin
    n_cleared = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (hit[r]) begin
        regs_d[r].is_virtual = 1'b0;
        regs_d[r].value      = hit_value[r];
      end
      if (flush_i) begin
        regs_d[r].is_virtual = 1'b0;
      end
      if (issue_eff && (issue_dst_i == RIDX_W'(r))) begin
        regs_d[r] = '{is_virtual: 1'b1, rs_id: issue_rs_i, value: regs_q[r].value};
      end else if (hit[r]) begin
        n_cleared = n_cleared + PCNT_W'(1);
      end
    end
  end

  assign cnt_d = flush_i ? '0 : (cnt_q + PCNT_W'(issue_new) - n_cleared);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      if (hit[read_reg_i[p]]) begin
        read_value_o[p] = '{is_virtual: 1'b0, rs_id: regs_q[read_reg_i[p]].rs_id,
                            value: hit_value[read_reg_i[p]]};
      end else begin
        read_value_o[p] = regs_q[read_reg_i[p]];
      end
    end
  end

  assign pending_cnt_o = cnt_q;

  always_comb begin
    virt_pop = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      virt_pop = virt_pop + PCNT_W'(regs_q[r].is_virtual);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BCAST; i++) begin
        for (int j = i + 1; j < NUM_BCAST; j++) begin
          assert (!(bcast_valid_i[i] && bcast_valid_i[j] && (bcast_rs_i[i] == bcast_rs_i[j])))
            else $error("duplicate broadcast tag on channels %0d and %0d", i, j);
        end
      end
      assert (cnt_q == virt_pop)
        else $error("pending count %0d disagrees with virtual popcount %0d", cnt_q, virt_pop);
    end
  end

endmodule
